// File: rtl/cpu_mem_pkg.sv
// Shared CPU <-> data memory definitions: FSM states, word geometry and request payload.
package cpu_mem_pkg;

  localparam int unsigned WORD_BYTES = 3;
  localparam int unsigned WORD_W     = 24;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CNT_W      = 2;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ACCESS,
    DRAIN,
    RESP
  } state_e;

  typedef struct packed {
    logic              write;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

  // Byte lane of a word, index 0 is the most significant byte (big-endian).
  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                  input logic [CNT_W-1:0]  idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = w[23:16];
      2'd1:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/data_mem_initiator.sv
// Load/store initiator: splits one 24-bit request into three big-endian byte
// accesses to a synchronous-read byte memory and returns a held response.
module data_mem_initiator
  import cpu_mem_pkg::*;
#(
  parameter  int unsigned MEM_BYTES  = 128,
  parameter  int unsigned RESV_BYTES = 10,
  localparam int unsigned MA_W       = $clog2(MEM_BYTES)
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [WORD_W-1:0] ReqAddr,
  input  logic [WORD_W-1:0] ReqWData,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [WORD_W-1:0] RspData,
  output logic              RspError,
  output logic [MA_W-1:0]   MemAddr,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [BYTE_W-1:0] MemWData,
  input  logic [BYTE_W-1:0] MemRData
);

  localparam int unsigned SH_W = (WORD_BYTES - 1) * BYTE_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BYTES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_req_t          req_q, req_d;
  logic [SH_W-1:0]   shreg_q, shreg_d;

  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_error_q, rsp_error_d;
  logic [MA_W-1:0]   mem_addr_q, mem_addr_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [BYTE_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              out_of_range_c;
  logic              reserved_c;

  // Widened by one bit so addresses near 2^24 cannot wrap into range.
  assign out_of_range_c = ({1'b0, req_q.addr} + 25'd2) > 25'(MEM_BYTES - 1);
  assign reserved_c     = req_q.write && (req_q.addr < WORD_W'(RESV_BYTES));

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    shreg_d     = shreg_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;

    case (state_q)
      IDLE: begin
        if (ReqValid && req_ready_q) begin
          req_d   = '{write: ReqWrite, addr: ReqAddr, wdata: ReqWData};
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (out_of_range_c || reserved_c) begin
          state_d     = RESP;
          rsp_error_d = 1'b1;
          rsp_data_d  = '0;
        end else begin
          state_d = ACCESS;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        // Read data lags its strobe by one cycle, so byte n lands while counter is n+1.
        if (!req_q.write && (cnt_q != '0)) begin
          shreg_d = {shreg_q[SH_W-BYTE_W-1:0], MemRData};
        end
        if (cnt_q == LAST_CNT) begin
          state_d     = req_q.write ? RESP : DRAIN;
          rsp_error_d = 1'b0;
          rsp_data_d  = '0;
        end else begin
          cnt_d = CNT_W'(cnt_q + 2'd1);
        end
      end
      DRAIN: begin
        state_d    = RESP;
        rsp_data_d = {shreg_q, MemRData};
      end
      RESP: begin
        if (rsp_valid_q && RspReady) begin
          state_d     = IDLE;
          rsp_error_d = 1'b0;
          rsp_data_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    mem_read_d  = (state_d == ACCESS) && !req_d.write;
    mem_write_d = (state_d == ACCESS) && req_d.write;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (state_d == ACCESS) begin
      mem_addr_d = MA_W'(req_d.addr + WORD_W'(cnt_d));
      if (req_d.write) begin
        mem_wdata_d = word_byte(req_d.wdata, cnt_d);
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      shreg_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      shreg_q     <= shreg_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      mem_addr_q  <= mem_addr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ReqReady = req_ready_q;
  assign RspValid = rsp_valid_q;
  assign RspData  = rsp_data_q;
  assign RspError = rsp_error_q;
  assign MemAddr  = mem_addr_q;
  assign MemRead  = mem_read_q;
  assign MemWrite = mem_write_q;
  assign MemWData = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_initiator.sv
// Bench for data_mem_initiator: byte memory model, vector table with a response
// scoreboard, and a hand-written mid-store reset sequence.
module tb_data_mem_initiator;
  import cpu_mem_pkg::*;

  localparam int unsigned MEM_BYTES = 128;
  localparam int unsigned MA_W      = 7;
  localparam int          NVEC      = 14;

  logic              Clock = 1'b0;
  logic              ResetN;
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [23:0]       ReqAddr;
  logic [23:0]       ReqWData;
  logic              RspValid;
  logic              RspReady;
  logic [23:0]       RspData;
  logic              RspError;
  logic [MA_W-1:0]   MemAddr;
  logic              MemRead;
  logic              MemWrite;
  logic [7:0]        MemWData;
  logic [7:0]        MemRData = 8'h00;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [23:0] wdata;
    int          hold;
    logic        exp_err;
    logic [23:0] exp_data;
  } vec_t;

  typedef struct {
    logic [23:0] data;
    logic        err;
  } exp_t;

  vec_t vecs[NVEC];
  exp_t sbq[$];

  data_mem_initiator #(.MEM_BYTES(128), .RESV_BYTES(10)) dut (
    .Clock(Clock), .ResetN(ResetN),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspError(RspError),
    .MemAddr(MemAddr), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemWData(MemWData), .MemRData(MemRData)
  );

  always #5 Clock = ~Clock;

  // Synchronous-read byte memory, preloaded on the first clock.
  logic [7:0] mem [MEM_BYTES];
  logic       preload_done = 1'b0;
  always @(posedge Clock) begin
    if (!preload_done) begin
      for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] <= 8'h00;
      mem[7'h00] <= 8'h9A; mem[7'h01] <= 8'hBC; mem[7'h02] <= 8'hDE;
      mem[7'h05] <= 8'h01; mem[7'h06] <= 8'h02; mem[7'h07] <= 8'h03;
      mem[7'h7D] <= 8'hAB; mem[7'h7E] <= 8'hCD; mem[7'h7F] <= 8'hEF;
      preload_done <= 1'b1;
    end else begin
      if (MemWrite) mem[MemAddr] <= MemWData;
      if (MemRead)  MemRData     <= mem[MemAddr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(ReqReady), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(RspValid), 32'd0);
    chk({tag, "_rsp_data"},  32'(RspData),  32'd0);
    chk({tag, "_rsp_error"}, 32'(RspError), 32'd0);
    chk({tag, "_mem_addr"},  32'(MemAddr),  32'd0);
    chk({tag, "_mem_read"},  32'(MemRead),  32'd0);
    chk({tag, "_mem_write"}, 32'(MemWrite), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(MemWData), 32'd0);
  endtask

  // Issue one request at cycle 0 and follow it through to its response.
  task automatic run_req(input vec_t v, input int idx);
    int          wait_cyc;
    int          exp_cyc;
    int          cyc;
    bit          seen;
    bit          exp_w;
    bit          exp_r;
    logic [6:0]  exp_a;
    logic [23:0] shifted;
    exp_t        e;
    string       tag;

    tag = $sformatf("v%0d", idx);
    wait_cyc = 0;
    while (!ReqReady && wait_cyc < 10) begin
      @(posedge Clock); #1;
      wait_cyc++;
    end
    chk({tag, "_req_ready_idle"}, 32'(ReqReady), 32'd1);

    ReqValid = 1'b1;
    ReqWrite = v.wr;
    ReqAddr  = v.addr;
    ReqWData = v.wdata;
    RspReady = (v.hold == 0);
    sbq.push_back('{data: v.exp_data, err: v.exp_err});
    exp_cyc = v.exp_err ? 2 : (v.wr ? 5 : 6);

    seen = 1'b0;
    cyc  = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge Clock); #1;
      if (c == 1) ReqValid = 1'b0;
      if (RspValid) begin
        seen = 1'b1;
        cyc  = c;
        break;
      end
      chk({tag, "_req_ready_busy"}, 32'(ReqReady), 32'd0);
      exp_w = !v.exp_err && v.wr  && (c >= 2) && (c <= 4);
      exp_r = !v.exp_err && !v.wr && (c >= 2) && (c <= 4);
      chk($sformatf("%s_c%0d_mem_write", tag, c), 32'(MemWrite), 32'(exp_w));
      chk($sformatf("%s_c%0d_mem_read", tag, c),  32'(MemRead),  32'(exp_r));
      if (exp_w || exp_r) begin
        exp_a = 7'(v.addr + 24'(c - 2));
        chk($sformatf("%s_c%0d_mem_addr", tag, c), 32'(MemAddr), 32'(exp_a));
      end
      if (exp_w) begin
        shifted = v.wdata >> (8 * (4 - c));
        chk($sformatf("%s_c%0d_mem_wdata", tag, c), 32'(MemWData), 32'(shifted[7:0]));
      end
    end

    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_rsp_timeout: got no RspValid, expected at cycle %0d", tag, exp_cyc);
      if (sbq.size() > 0) void'(sbq.pop_front());
      RspReady = 1'b1;
      return;
    end
    chk({tag, "_rsp_cycle"}, 32'(cyc), 32'(exp_cyc));

    // Stall the response; a competing request must not be taken meanwhile.
    for (int h = 0; h < v.hold; h++) begin
      ReqValid = 1'b1;
      ReqWrite = 1'b0;
      ReqAddr  = 24'h30;
      chk($sformatf("%s_h%0d_rsp_valid", tag, h), 32'(RspValid), 32'd1);
      chk($sformatf("%s_h%0d_rsp_data", tag, h),  32'(RspData),  32'(v.exp_data));
      chk($sformatf("%s_h%0d_req_ready", tag, h), 32'(ReqReady), 32'd0);
      @(posedge Clock); #1;
    end
    ReqValid = 1'b0;
    RspReady = 1'b1;

    chk({tag, "_rsp_valid"}, 32'(RspValid), 32'd1);
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: got empty queue, expected one entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_rsp_data"},  32'(RspData),  32'(e.data));
      chk({tag, "_rsp_error"}, 32'(RspError), 32'(e.err));
    end

    @(posedge Clock); #1;
    chk({tag, "_req_ready_after"}, 32'(ReqReady), 32'd1);
    chk({tag, "_rsp_valid_after"}, 32'(RspValid), 32'd0);
  endtask

  initial begin
    vec_t rv;

    ResetN   = 1'b0;
    ReqValid = 1'b0;
    ReqWrite = 1'b0;
    ReqAddr  = '0;
    ReqWData = '0;
    RspReady = 1'b0;

    repeat (2) @(posedge Clock);
    #1;
    chk_outputs_zero("reset");
    @(negedge Clock) ResetN = 1'b1;
    @(posedge Clock); #1;
    chk("reset_release_req_ready", 32'(ReqReady), 32'd1);

    vecs[0]  = '{1'b1, 24'h000020, 24'h123456, 0,  1'b0, 24'h000000};
    vecs[1]  = '{1'b0, 24'h000020, 24'h000000, 0,  1'b0, 24'h123456};
    vecs[2]  = '{1'b0, 24'h00007D, 24'h000000, 0,  1'b0, 24'hABCDEF};
    vecs[3]  = '{1'b1, 24'h000005, 24'hFFFFFF, 0,  1'b1, 24'h000000};
    vecs[4]  = '{1'b0, 24'h000005, 24'h000000, 0,  1'b0, 24'h010203};
    vecs[5]  = '{1'b0, 24'h00007E, 24'h000000, 0,  1'b1, 24'h000000};
    vecs[6]  = '{1'b0, 24'hFFFFFF, 24'h000000, 0,  1'b1, 24'h000000};
    vecs[7]  = '{1'b1, 24'h00007D, 24'h55AA77, 10, 1'b0, 24'h000000};
    vecs[8]  = '{1'b0, 24'h00007D, 24'h000000, 0,  1'b0, 24'h55AA77};
    vecs[9]  = '{1'b1, 24'h000009, 24'h111111, 0,  1'b1, 24'h000000};
    vecs[10] = '{1'b1, 24'h00000A, 24'hC0FFEE, 0,  1'b0, 24'h000000};
    vecs[11] = '{1'b0, 24'h00000A, 24'h000000, 0,  1'b0, 24'hC0FFEE};
    vecs[12] = '{1'b1, 24'h00007E, 24'h222222, 0,  1'b1, 24'h000000};
    vecs[13] = '{1'b0, 24'h000000, 24'h000000, 3,  1'b0, 24'h9ABCDE};

    for (int i = 0; i < NVEC; i++) run_req(vecs[i], i);

    // Reset while the second byte of a store is on the bus.
    ReqValid = 1'b1;
    ReqWrite = 1'b1;
    ReqAddr  = 24'h000040;
    ReqWData = 24'h445566;
    RspReady = 1'b1;
    @(posedge Clock); #1;
    ReqValid = 1'b0;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    chk("midrst_mem_write", 32'(MemWrite), 32'd1);
    chk("midrst_mem_addr",  32'(MemAddr),  32'h41);
    chk("midrst_mem_wdata", 32'(MemWData), 32'h55);
    #2 ResetN = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    repeat (2) @(posedge Clock);
    #1;
    chk("midrst_held_req_ready", 32'(ReqReady), 32'd0);
    @(negedge Clock) ResetN = 1'b1;
    @(posedge Clock); #1;
    chk("midrst_release_req_ready", 32'(ReqReady), 32'd1);
    chk("midrst_byte0_kept", 32'(mem[7'h40]), 32'h44);
    chk("midrst_byte1_unwritten", 32'(mem[7'h41]), 32'h00);
    chk("midrst_byte2_unwritten", 32'(mem[7'h42]), 32'h00);

    rv = '{1'b0, 24'h000040, 24'h000000, 0, 1'b0, 24'h440000};
    run_req(rv, 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
